// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - MEM-stage result and load-response bus into the writeback unit
//
// Signals:
//   in_valid / in_ready   result handshake (ready is driven by the unit)
//   in_wb                 WB bundle {rw_F, rw_R, rw_P, RegMem}
//   in_dst                destination register id
//   in_alu                ALU result
//   in_pz                 predicate result bit
//   mem_rsp_valid         load data valid, single-cycle pulse
//   mem_rsp_data          load data
// Modports: master drives results and load responses, slave is the writeback unit.

interface writeback_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_wb;
  logic [3:0]  in_dst;
  logic [31:0] in_alu;
  logic        in_pz;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport master (
    output in_valid, in_wb, in_dst, in_alu, in_pz, mem_rsp_valid, mem_rsp_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_wb, in_dst, in_alu, in_pz, mem_rsp_valid, mem_rsp_data,
    output in_ready
  );
endinterface

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - final pipeline stage driving the register-file write ports
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   bus (slave)         MEM-stage result handshake and load response
//   rw[2:0]             write strobes {freg, greg, preg}, one-cycle pulses
//   Pz_id, Pz           predicate register write port
//   Rz_id, Rz           general register write port
//   Fz_id, Fz           FP register write port (mirrors Rz_id/Rz)
//   retire_cnt          instructions written back
//   squash_cnt          accepted results with an all-zero WB bundle
//   err[1:0]            sticky {spurious load response, load timeout}

module writeback_unit #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  writeback_unit_if.slave    bus,
  output logic [2:0]         rw,
  output logic [1:0]         Pz_id,
  output logic               Pz,
  output logic [3:0]         Rz_id,
  output logic [31:0]        Rz,
  output logic [3:0]         Fz_id,
  output logic [31:0]        Fz,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   squash_cnt,
  output logic [1:0]         err
);

  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;

  // Load held while waiting for its data
  logic [3:0]       pend_wb;
  logic [3:0]       pend_dst;
  logic             pend_pz;

  logic             accept;
  logic             do_write;
  logic             from_pending;
  logic             do_hold;
  logic             do_squash;
  logic             do_timeout;
  logic             do_spurious;

  logic [3:0]       src_wb;
  logic [3:0]       src_dst;
  logic             src_pz;
  logic [31:0]      src_data;

  assign bus.in_ready = (state == S_IDLE) || (state == S_WRITE);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tmr_nxt      = tmr;
    do_write     = 1'b0;
    from_pending = 1'b0;
    do_hold      = 1'b0;
    do_squash    = 1'b0;
    do_timeout   = 1'b0;
    do_spurious  = 1'b0;
    unique case (state)
      S_IDLE, S_WRITE: begin
        // WRITE lasts one cycle; an accept here is handled exactly as in IDLE
        state_nxt = S_IDLE;
        if (accept) begin
          if (bus.in_wb == 4'd0) begin
            do_squash = 1'b1;
          end else if (!bus.in_wb[0] || bus.mem_rsp_valid) begin
            do_write  = 1'b1;
            state_nxt = S_WRITE;
          end else begin
            do_hold   = 1'b1;
            tmr_nxt   = '0;
            state_nxt = S_WAIT_MEM;
          end
        end
        // A response is only legitimate when it lands on the accept of a load
        if (bus.mem_rsp_valid && !(accept && bus.in_wb[0])) begin
          do_spurious = 1'b1;
        end
      end
      S_WAIT_MEM: begin
        tmr_nxt = tmr + 1'b1;
        if (bus.mem_rsp_valid) begin
          do_write     = 1'b1;
          from_pending = 1'b1;
          state_nxt    = S_WRITE;
        end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write source: the held load when its response arrives, otherwise the live input
  always_comb begin
    src_wb   = from_pending ? pend_wb  : bus.in_wb;
    src_dst  = from_pending ? pend_dst : bus.in_dst;
    src_pz   = from_pending ? pend_pz  : bus.in_pz;
    src_data = src_wb[0] ? bus.mem_rsp_data : bus.in_alu;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_wb    <= '0;
      pend_dst   <= '0;
      pend_pz    <= 1'b0;
      rw         <= '0;
      Pz_id      <= '0;
      Pz         <= 1'b0;
      Rz_id      <= '0;
      Rz         <= '0;
      retire_cnt <= '0;
      squash_cnt <= '0;
      err        <= '0;
    end else begin
      if (do_hold) begin
        pend_wb  <= bus.in_wb;
        pend_dst <= bus.in_dst;
        pend_pz  <= bus.in_pz;
      end
      rw <= do_write ? src_wb[3:1] : 3'b000;
      if (do_write) begin
        Pz_id      <= src_dst[1:0];
        Pz         <= src_pz;
        Rz_id      <= src_dst;
        Rz         <= src_data;
        retire_cnt <= retire_cnt + 1'b1;
      end
      if (do_squash) begin
        squash_cnt <= squash_cnt + 1'b1;
      end
      if (do_timeout) begin
        err[0] <= 1'b1;
      end
      if (do_spurious) begin
        err[1] <= 1'b1;
      end
    end
  end

  assign Fz_id = Rz_id;
  assign Fz    = Rz;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - scoreboard bench for writeback_unit

module tb_writeback_unit;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       rw;
  logic [1:0]       Pz_id;
  logic             Pz;
  logic [3:0]       Rz_id;
  logic [31:0]      Rz;
  logic [3:0]       Fz_id;
  logic [31:0]      Fz;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] squash_cnt;
  logic [1:0]       err;

  writeback_unit_if bus();

  writeback_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rw         (rw),
    .Pz_id      (Pz_id),
    .Pz         (Pz),
    .Rz_id      (Rz_id),
    .Rz         (Rz),
    .Fz_id      (Fz_id),
    .Fz         (Fz),
    .retire_cnt (retire_cnt),
    .squash_cnt (squash_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  rw;
    logic [1:0]  pz_id;
    logic        pz;
    logic [3:0]  rz_id;
    logic [31:0] rz;
    int          at;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_retire = 0;
  int   exp_squash = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write and land on its cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      mon_e = exp_q.pop_front();
      check("missed_write_cycle", 64'(cyc), 64'(mon_e.at));
    end
    if (rw !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(rw), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_cycle", 64'(cyc), 64'(mon_e.at));
        check("rw", 64'(rw), 64'(mon_e.rw));
        check("Pz_id", 64'(Pz_id), 64'(mon_e.pz_id));
        check("Pz", 64'(Pz), 64'(mon_e.pz));
        check("Rz_id", 64'(Rz_id), 64'(mon_e.rz_id));
        check("Rz", 64'(Rz), 64'(mon_e.rz));
        check("Fz_id", 64'(Fz_id), 64'(mon_e.rz_id));
        check("Fz", 64'(Fz), 64'(mon_e.rz));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one result; d = cycles from accept to load response (0 = same cycle)
  task automatic issue(input logic [3:0] wb, input logic [3:0] dst, input logic [31:0] alu,
                       input logic pz, input int d, input logic [31:0] rdata);
    int  acc;
    wr_t w;
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    acc             = cyc;
    bus.in_valid    = 1'b1;
    bus.in_wb       = wb;
    bus.in_dst      = dst;
    bus.in_alu      = alu;
    bus.in_pz       = pz;
    w.rw    = wb[3:1];
    w.pz_id = dst[1:0];
    w.pz    = pz;
    w.rz_id = dst;
    w.rz    = wb[0] ? rdata : alu;
    if (wb == 4'd0) begin
      exp_squash++;
    end else if (!wb[0] || d == 0) begin
      bus.mem_rsp_valid = wb[0];
      bus.mem_rsp_data  = rdata;
      w.at = acc + 1;
      exp_q.push_back(w);
      exp_retire++;
    end
    step();
    bus.in_valid      = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.in_wb         = 4'($urandom);
    bus.in_alu        = $urandom;
    bus.mem_rsp_data  = $urandom;
    if (wb != 4'd0 && wb[0] && d > 0) begin
      for (int i = 1; i < d; i++) begin
        check("in_ready_waiting", 64'(bus.in_ready), 64'd0);
        step();
      end
      check("in_ready_waiting", 64'(bus.in_ready), 64'd0);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = rdata;
      w.at = acc + d + 1;
      exp_q.push_back(w);
      exp_retire++;
      step();
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = $urandom;
    end
    check("retire_cnt", 64'(retire_cnt), 64'(exp_retire));
    check("squash_cnt", 64'(squash_cnt), 64'(exp_squash));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rw"}, 64'(rw), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_retire_cnt"}, 64'(retire_cnt), 64'd0);
    check({tag, "_squash_cnt"}, 64'(squash_cnt), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_Rz"}, 64'(Rz), 64'd0);
    check({tag, "_Rz_id"}, 64'(Rz_id), 64'd0);
    check({tag, "_Pz"}, 64'(Pz), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] wb;
    int         acc;

    bus.in_valid      = 1'b1;
    bus.in_wb         = 4'b0100;
    bus.in_dst        = 4'd7;
    bus.in_alu        = 32'h5555_AAAA;
    bus.in_pz         = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;

    // Reset held three cycles with a valid result presented
    rst = 1'b0;
    repeat (3) step();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    check_reset_state("reset");

    // Directed ALU, load, predicate and squash operations
    issue(4'b0100, 4'd5, 32'hDEADBEEF, 1'b0, 0, 32'h0);
    step();
    issue(4'b0101, 4'd3, 32'hFFFF_0000, 1'b0, 4, 32'h0000_1234);
    step();
    issue(4'b0010, 4'd2, 32'h0, 1'b1, 0, 32'h0);
    step();
    issue(4'b0000, 4'd9, 32'h0BAD_0BAD, 1'b1, 0, 32'h0);
    check("squash_once", 64'(squash_cnt), 64'd1);
    check("retire_after_squash", 64'(retire_cnt), 64'd3);
    step();

    // Back-to-back: each op accepted in the WRITE cycle of the one before
    issue(4'b1100, 4'd10, 32'h1111_2222, 1'b0, 0, 32'h0);
    issue(4'b1110, 4'd6, 32'h3333_4444, 1'b1, 0, 32'h0);
    issue(4'b0101, 4'd1, 32'h0, 1'b0, 0, 32'hCAFE_F00D);
    issue(4'b1001, 4'd15, 32'h0, 1'b1, 2, 32'h8765_4321);
    step();

    // Randomized traffic with idle gaps, in-WRITE accepts and load latencies
    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      if ($urandom_range(0, 7) == 0) wb = 4'd0;
      else wb = {3'($urandom_range(1, 7)), 1'($urandom)};
      issue(wb, 4'($urandom), $urandom, 1'($urandom), $urandom_range(0, 6), $urandom);
    end
    repeat (3) step();
    check("err_clean_after_traffic", 64'(err), 64'd0);

    // Load that never gets a response
    check("in_ready_before_timeout", 64'(bus.in_ready), 64'd1);
    acc          = cyc;
    bus.in_valid = 1'b1;
    bus.in_wb    = 4'b0101;
    bus.in_dst   = 4'd4;
    step();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      check("in_ready_timeout_wait", 64'(bus.in_ready), 64'd0);
      check("err0_before_timeout", 64'(err[0]), 64'd0);
      step();
    end
    check("timeout_elapsed_cycles", 64'(cyc - acc), 64'(TIMEOUT + 1));
    check("err0_after_timeout", 64'(err[0]), 64'd1);
    check("in_ready_after_timeout", 64'(bus.in_ready), 64'd1);
    check("retire_after_timeout", 64'(retire_cnt), 64'(exp_retire));

    // Stray load response while idle
    check("err1_before_stray", 64'(err[1]), 64'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h7777_7777;
    step();
    bus.mem_rsp_valid = 1'b0;
    check("err1_after_stray", 64'(err[1]), 64'd1);
    check("err_sticky", 64'(err), 64'd3);

    // Reset while a load is pending: the load is never written
    issue(4'b0010, 4'd1, 32'h0, 1'b0, 0, 32'h0);
    bus.in_valid = 1'b1;
    bus.in_wb    = 4'b0101;
    bus.in_dst   = 4'd8;
    step();
    bus.in_valid = 1'b0;
    check("in_ready_pending_load", 64'(bus.in_ready), 64'd0);
    step();
    rst = 1'b0;
    exp_retire = 0;
    exp_squash = 0;
    step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h9999_9999;
    step();
    bus.mem_rsp_valid = 1'b0;
    rst = 1'b1;
    check_reset_state("reset_in_wait");
    repeat (8) step();
    check("no_write_after_drop", 64'(retire_cnt), 64'd0);
    issue(4'b1000, 4'd12, 32'hABCD_0123, 1'b0, 0, 32'h0);
    repeat (4) step();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
